// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
//   tx_state_e  : serializer FSM states
//   *_DEFAULT   : default sizing for FIFO depth and oversampling
//   parity_bit  : parity over one byte, even (odd=0) or odd (odd=1)
package uart_tx_buffered_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int OVS_DEFAULT        = 16;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  // Even parity makes the total count of ones (data + parity) even.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write port of the buffered UART transmitter.
//   wr_en/wr_data : producer pushes one byte per cycle
//   full/empty    : FIFO status
//   count         : FIFO occupancy (byte in the serializer not included)
//   overflow      : 1-clk pulse, a write arrived while full and was dropped
// master = producer side, slave = transmitter side.
interface uart_tx_buffered_if
  import uart_tx_buffered_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (output wr_en, wr_data, input full, empty, count, overflow);
  modport slave  (input wr_en, wr_data, output full, empty, count, overflow);

endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO in front of the serializer.
//   clk, rst           : clock, async active-high reset
//   wr_en, wr_data     : push request; dropped (overflow pulse) when full
//   rd_en, rd_data     : pop request; rd_data shows the head combinationally
//   full, empty, count : status derived from the registered occupancy
//   overflow           : registered 1-clk pulse for a dropped write
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_buffered_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Gated on the registered full: a same-cycle pop never makes room.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow <= wr_en & full;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a b_tick-timed serializer.
//   clk, rst  : clock, async active-high reset
//   b_tick    : 1-clk pulse at baud*OVS
//   wr_if     : byte write port (push, full/empty/count/overflow)
//   tx_busy   : serializer mid-frame
//   tx_done   : 1-clk pulse after the last stop bit
//   uart_tx   : serial line, idle high, registered
// Frame: start(0), D0..D7 LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int OVS        = OVS_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b_tick,
  uart_tx_buffered_if.slave  wr_if,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               uart_tx
);

  // Tick counter must reach 2*OVS-1 for two stop bits.
  localparam int TW = $clog2(2 * OVS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * OVS - 1);

  tx_state_e     state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          par, par_n;
  logic          pop, done_n, tx_n;
  logic [7:0]    head;

  uart_tx_buffered_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_if.wr_en),
    .wr_data  (wr_if.wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (wr_if.full),
    .empty    (wr_if.empty),
    .count    (wr_if.count),
    .overflow (wr_if.overflow)
  );

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    par_n   = par;
    pop     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // b_tick ignored here; the next frame starts as soon as a byte waits.
        if (!wr_if.empty) begin
          pop     = 1'b1;
          sh_n    = head;
          par_n   = parity_bit(head, PARITY_ODD != 0);
          tick_n  = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_n  = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_n = '0;
            if (bit_cnt == 3'd7) begin
              state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              sh_n  = shreg >> 1;
              bit_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      PARITY: begin
        if (b_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_n  = '0;
            state_n = STOP;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_n  = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so uart_tx stays registered
    // without lagging the FSM by a cycle.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      par      <= par_n;
      uart_tx  <= tx_n;
      tx_busy  <= (state_n != IDLE);
      tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (8N1, 8E2, 8O2) share one
// stimulus stream. Each has a frame-level model: a byte queue for the FIFO and
// an expected bit list per frame indexed by the number of b_ticks elapsed.
module tb_uart_tx_buffered;

  localparam int DEPTH = 16;
  localparam int OVS   = 16;

  logic       clk, rst, b_tick, tick_en;
  logic       wr_en;
  logic [7:0] wr_data;
  int         checks   = 0;
  int         failures = 0;
  int         peak;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    b_tick = 1'b0;
    forever begin
      @(negedge clk);
      b_tick = tick_en && ($urandom_range(0, 1) == 1);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int P_EN  = (g == 0) ? 0 : 1;
    localparam int P_ODD = (g == 2) ? 1 : 0;
    localparam int SB    = (g == 0) ? 1 : 2;
    localparam int NTICK = (9 + P_EN + SB) * OVS;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) ifc();
    logic busy_o, done_o, tx_o;

    assign ifc.wr_en   = wr_en;
    assign ifc.wr_data = wr_data;

    uart_tx_buffered #(
      .FIFO_DEPTH (DEPTH),
      .OVS        (OVS),
      .PARITY_EN  (P_EN),
      .PARITY_ODD (P_ODD),
      .STOP_BITS  (SB)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .b_tick  (b_tick),
      .wr_if   (ifc),
      .tx_busy (busy_o),
      .tx_done (done_o),
      .uart_tx (tx_o)
    );

    logic [7:0]  q[$];
    logic [11:0] fr;
    bit          m_busy = 1'b0;
    bit          idle_f = 1'b1;
    int          k      = 0;

    always @(posedge clk) begin
      logic       tk, we, full_b, ovf, done, exp_tx;
      logic [7:0] d, cur;
      tk = b_tick;
      we = wr_en;
      d  = wr_data;
      #1;
      full_b = (q.size() == DEPTH);
      ovf    = we && full_b;
      done   = 1'b0;
      if (rst) begin
        q.delete();
        m_busy = 1'b0;
        k      = 0;
        ovf    = 1'b0;
      end else begin
        if (!m_busy) begin
          if (q.size() > 0) begin
            cur      = q.pop_front();
            fr       = '1;
            fr[0]    = 1'b0;
            fr[8:1]  = cur;
            if (P_EN != 0) fr[9] = (($countones(cur) % 2) == 1) ^ (P_ODD != 0);
            m_busy   = 1'b1;
            k        = 0;
          end
        end else if (tk) begin
          k++;
          if (k == NTICK) begin
            m_busy = 1'b0;
            done   = 1'b1;
          end
        end
        if (we && !full_b) q.push_back(d);
      end
      idle_f = !m_busy && (q.size() == 0);
      exp_tx = m_busy ? fr[4'(k / OVS)] : 1'b1;
      chk($sformatf("c%0d.uart_tx", g),  32'(tx_o),         32'(exp_tx));
      chk($sformatf("c%0d.tx_busy", g),  32'(busy_o),       32'(m_busy));
      chk($sformatf("c%0d.tx_done", g),  32'(done_o),       32'(done));
      chk($sformatf("c%0d.count", g),    32'(ifc.count),    32'(q.size()));
      chk($sformatf("c%0d.empty", g),    32'(ifc.empty),    32'(q.size() == 0));
      chk($sformatf("c%0d.full", g),     32'(ifc.full),     32'(q.size() == DEPTH));
      chk($sformatf("c%0d.overflow", g), 32'(ifc.overflow), 32'(ovf));
    end
  end

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(cfg[0].idle_f && cfg[1].idle_f && cfg[2].idle_f) && n < max) begin
      @(negedge clk);
      n++;
      if (int'(cfg[0].ifc.count) > peak) peak = int'(cfg[0].ifc.count);
    end
    chk("drain_in_time", 32'(n < max), 32'(1));
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tick_en = 1'b0;
    peak    = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, nothing written yet.
    chk("rst.uart_tx", 32'(cfg[0].tx_o),      32'(1));
    chk("rst.empty",   32'(cfg[0].ifc.empty), 32'(1));
    chk("rst.count",   32'(cfg[0].ifc.count), 32'(0));
    chk("rst.tx_busy", 32'(cfg[0].busy_o),    32'(0));

    // Single 0x55 frame.
    tick_en = 1'b1;
    push_byte(8'h55);
    wait_idle(4000);

    // Burst of four bytes on consecutive clocks.
    peak = 0;
    push_byte(8'hA5);
    push_byte(8'h3C);
    push_byte(8'hFF);
    push_byte(8'h00);
    wait_idle(8000);
    chk("burst.peak",  32'(peak), 32'(3));
    chk("burst.empty", 32'(cfg[0].ifc.empty), 32'(1));

    // Overflow: no ticks, so the first byte parks in the serializer.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      @(negedge clk);
      if (i == 15) chk("ovf.full_before_17", 32'(cfg[0].ifc.full), 32'(0));
      if (i == 16) chk("ovf.full_after_17",  32'(cfg[0].ifc.full), 32'(1));
    end
    wr_en = 1'b0;
    chk("ovf.pulse", 32'(cfg[0].ifc.overflow), 32'(1));
    chk("ovf.count", 32'(cfg[0].ifc.count),    32'(16));
    tick_en = 1'b1;
    wait_idle(20000);

    // Parity bit for 0x07: even -> 1, odd -> 0.
    push_byte(8'h07);
    n = 0;
    while (!(cfg[1].m_busy && (cfg[1].k / OVS) == 9) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("par.reached",  32'(n < 4000),       32'(1));
    chk("par.even_bit", 32'(cfg[1].tx_o),    32'(1));
    chk("par.odd_bit",  32'(cfg[2].tx_o),    32'(0));
    wait_idle(4000);

    // Reset in the middle of data bit 3.
    push_byte(8'h00);
    n = 0;
    while (!(cfg[0].m_busy && cfg[0].k >= 4 * OVS + 3) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("mid.reached", 32'(n < 4000), 32'(1));
    #3 rst = 1'b1;
    #1;
    chk("mid.c0_uart_tx", 32'(cfg[0].tx_o),      32'(1));
    chk("mid.c1_uart_tx", 32'(cfg[1].tx_o),      32'(1));
    chk("mid.c2_uart_tx", 32'(cfg[2].tx_o),      32'(1));
    chk("mid.count",      32'(cfg[0].ifc.count), 32'(0));
    chk("mid.tx_busy",    32'(cfg[0].busy_o),    32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_byte(8'h81);
    wait_idle(4000);

    // Random traffic with random gaps (may overflow at times).
    for (int i = 0; i < 30; i++) begin
      push_byte(8'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle(30000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
